// File: rtl/spdif_lock_ctrl.sv
// S/PDIF receiver lock controller: measures the unit interval, verifies preambles, then supervises lock.
// Optional feature: define SPDIF_LOCK_TRACK_EN to let ui follow +/-1 drifts while LOCKED.
module spdif_lock_ctrl (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       enable,
  input  logic       bitedge_detected,
  input  logic [7:0] bitlength,
  input  logic       sync_found,
  output logic       dec_resetb,
  output logic [7:0] t1,
  output logic [7:0] t2,
  output logic [7:0] t3,
  output logic       audio_locked,
  output logic [1:0] lock_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_VERIFY  = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;

  logic [1:0]  r_state;
  logic [5:0]  r_edge_cnt;
  logic [7:0]  r_min_len;
  logic [7:0]  r_ui;
  logic [2:0]  r_sync_cnt;
  logic [11:0] r_timer;
  logic [10:0] r_wd;
  logic [3:0]  r_err_cnt;
  logic [7:0]  r_t1;
  logic [7:0]  r_t2;
  logic [7:0]  r_t3;
  logic        r_dec_resetb;
  logic        r_audio_locked;
  logic [1:0]  r_lock_state;

  logic [1:0]  w_nstate;
  logic [5:0]  w_nedge;
  logic [7:0]  w_nmin;
  logic [7:0]  w_nui;
  logic [2:0]  w_nsync;
  logic [11:0] w_ntimer;
  logic [10:0] w_nwd;
  logic [3:0]  w_nerr;
  logic        w_clear;

  logic [7:0]  w_min_cand;
  logic        w_win_end;
  logic        w_min_ok;
  logic [9:0]  w_lo_lim;
  logic [9:0]  w_hi_lim;
  logic        w_bad_edge;
  logic        w_timer_exp;
  logic        w_wd_exp;
  logic        w_err_exp;
  logic [9:0]  w_t1_full;
  logic [9:0]  w_t2_full;
  logic [9:0]  w_t3_full;

  assign w_min_cand = (bitlength < r_min_len) ? bitlength : r_min_len;
  assign w_win_end  = bitedge_detected && (r_edge_cnt == 6'd63);
  assign w_min_ok   = (w_min_cand >= 8'd4) && (w_min_cand <= 8'd80);

  // Plausible interval band while locked: [ui - ui/4, 4*ui].
  assign w_lo_lim   = {2'b00, r_ui} - {4'b0000, r_ui[7:2]};
  assign w_hi_lim   = {r_ui, 2'b00};
  assign w_bad_edge = bitedge_detected &&
                      (({2'b00, bitlength} < w_lo_lim) || ({2'b00, bitlength} > w_hi_lim));

  // Timeouts fire on the cycle the counter would reach its terminal value.
  assign w_timer_exp = (r_timer >= 12'd4094);
  assign w_wd_exp    = (r_wd >= 11'd2046);
  assign w_err_exp   = w_bad_edge && (r_err_cnt >= 4'd7);

  assign w_t1_full = {2'b00, r_ui} + {3'b000, r_ui[7:1]};
  assign w_t2_full = {1'b0, r_ui, 1'b0} + {3'b000, r_ui[7:1]};
  assign w_t3_full = {1'b0, r_ui, 1'b0} + {2'b00, r_ui} - {4'b0000, r_ui[7:2]};

`ifdef SPDIF_LOCK_TRACK_EN
  logic w_track_step;
  assign w_track_step = ({1'b0, w_min_cand} == ({1'b0, r_ui} + 9'd1)) ||
                        (({1'b0, w_min_cand} + 9'd1) == {1'b0, r_ui});
`endif

  always_comb begin
    w_nstate = r_state;
    w_nedge  = r_edge_cnt;
    w_nmin   = r_min_len;
    w_nui    = r_ui;
    w_nsync  = r_sync_cnt;
    w_ntimer = r_timer;
    w_nwd    = r_wd;
    w_nerr   = r_err_cnt;
    w_clear  = 1'b0;
    if (!enable) begin
      w_nstate = S_IDLE;
      w_clear  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nstate = S_MEASURE;
          w_clear  = 1'b1;
        end
        S_MEASURE: begin
          if (bitedge_detected) begin
            if (w_win_end) begin
              w_nedge = 6'd0;
              w_nmin  = 8'd255;
              if (w_min_ok) begin
                w_nui    = w_min_cand;
                w_nstate = S_VERIFY;
              end
            end else begin
              w_nedge = r_edge_cnt + 6'd1;
              w_nmin  = w_min_cand;
            end
          end
        end
        S_VERIFY: begin
          w_ntimer = (r_timer == 12'hfff) ? r_timer : r_timer + 12'd1;
          if (sync_found) begin
            if (r_sync_cnt == 3'd3) begin
              w_nstate = S_LOCKED;
              w_nsync  = 3'd0;
              w_ntimer = 12'd0;
              w_nwd    = 11'd0;
              w_nerr   = 4'd0;
              w_nedge  = 6'd0;
              w_nmin   = 8'd255;
            end else begin
              w_nsync = r_sync_cnt + 3'd1;
            end
          end else if (w_timer_exp) begin
            w_nstate = S_MEASURE;
            w_clear  = 1'b1;
          end
        end
        default: begin
`ifdef SPDIF_LOCK_TRACK_EN
          if (bitedge_detected) begin
            if (w_win_end) begin
              w_nedge = 6'd0;
              w_nmin  = 8'd255;
              if (w_track_step) w_nui = w_min_cand;
            end else begin
              w_nedge = r_edge_cnt + 6'd1;
              w_nmin  = w_min_cand;
            end
          end
`endif
          // A sync pulse always wins over a coincident timeout or error overflow.
          if (sync_found) begin
            w_nwd  = 11'd0;
            w_nerr = 4'd0;
          end else if (w_wd_exp || w_err_exp) begin
            w_nstate = S_MEASURE;
            w_clear  = 1'b1;
          end else begin
            w_nwd = (r_wd == 11'h7ff) ? r_wd : r_wd + 11'd1;
            if (w_bad_edge && (r_err_cnt != 4'hf)) w_nerr = r_err_cnt + 4'd1;
          end
        end
      endcase
    end
    if (w_clear) begin
      w_nedge  = 6'd0;
      w_nmin   = 8'd255;
      w_nsync  = 3'd0;
      w_ntimer = 12'd0;
      w_nwd    = 11'd0;
      w_nerr   = 4'd0;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_edge_cnt     <= 6'd0;
      r_min_len      <= 8'd255;
      r_ui           <= 8'd14;
      r_sync_cnt     <= 3'd0;
      r_timer        <= 12'd0;
      r_wd           <= 11'd0;
      r_err_cnt      <= 4'd0;
      r_t1           <= 8'd21;
      r_t2           <= 8'd35;
      r_t3           <= 8'd39;
      r_dec_resetb   <= 1'b0;
      r_audio_locked <= 1'b0;
      r_lock_state   <= S_IDLE;
    end else begin
      r_state        <= w_nstate;
      r_edge_cnt     <= w_nedge;
      r_min_len      <= w_nmin;
      r_ui           <= w_nui;
      r_sync_cnt     <= w_nsync;
      r_timer        <= w_ntimer;
      r_wd           <= w_nwd;
      r_err_cnt      <= w_nerr;
      // Thresholds follow the registered ui, so they trail a ui change by one cycle.
      r_t1           <= (|w_t1_full[9:8]) ? 8'hff : w_t1_full[7:0];
      r_t2           <= (|w_t2_full[9:8]) ? 8'hff : w_t2_full[7:0];
      r_t3           <= (|w_t3_full[9:8]) ? 8'hff : w_t3_full[7:0];
      r_dec_resetb   <= w_nstate[1];
      r_audio_locked <= (w_nstate == S_LOCKED);
      r_lock_state   <= w_nstate;
    end
  end

  assign dec_resetb   = r_dec_resetb;
  assign audio_locked = r_audio_locked;
  assign lock_state   = r_lock_state;
  assign t1           = r_t1;
  assign t2           = r_t2;
  assign t3           = r_t3;

endmodule

// File: tb/tb_spdif_lock_ctrl.sv
// Self-checking bench for spdif_lock_ctrl: threshold table, multi-cycle corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_spdif_lock_ctrl;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       enable;
  logic       bitedge_detected;
  logic [7:0] bitlength;
  logic       sync_found;
  logic       dec_resetb;
  logic [7:0] t1;
  logic [7:0] t2;
  logic [7:0] t3;
  logic       audio_locked;
  logic [1:0] lock_state;

  int checks   = 0;
  int failures = 0;

  spdif_lock_ctrl dut (
    .clk_in          (clk_in),
    .reset           (reset),
    .enable          (enable),
    .bitedge_detected(bitedge_detected),
    .bitlength       (bitlength),
    .sync_found      (sync_found),
    .dec_resetb      (dec_resetb),
    .t1              (t1),
    .t2              (t2),
    .t3              (t3),
    .audio_locked    (audio_locked),
    .lock_state      (lock_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  // reference model: state by name number, window as a queue of lengths, timeouts by cycle stamps
  int m_st;
  int m_ui;
  int m_t1;
  int m_t2;
  int m_t3;
  int m_sync;
  int m_err;
  int m_ref;
  int cyc;
  int win_q[$];

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int q_min();
    int mn = 255;
    foreach (win_q[k]) if (win_q[k] < mn) mn = win_q[k];
    return mn;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ui = 14; m_t1 = 21; m_t2 = 35; m_t3 = 39;
    m_sync = 0; m_err = 0; m_ref = 0; cyc = 0;
    win_q.delete();
  endtask

  task automatic model_enter_measure();
    m_st = 1; m_sync = 0; m_err = 0;
    win_q.delete();
  endtask

  task automatic model_step(input logic en, input logic be, input int len, input logic sy);
    int nt1, nt2, nt3, mn, lo;
    logic bad;
    cyc++;
    nt1 = sat8(m_ui + m_ui / 2);
    nt2 = sat8(2 * m_ui + m_ui / 2);
    nt3 = sat8(3 * m_ui - m_ui / 4);
    if (!en) begin
      m_st = 0; m_sync = 0; m_err = 0;
      win_q.delete();
    end else if (m_st == 0) begin
      model_enter_measure();
    end else if (m_st == 1) begin
      if (be) begin
        win_q.push_back(len);
        if (win_q.size() == 64) begin
          mn = q_min();
          win_q.delete();
          if (mn >= 4 && mn <= 80) begin
            m_ui = mn; m_st = 2; m_ref = cyc; m_sync = 0;
          end
        end
      end
    end else if (m_st == 2) begin
      if (sy) begin
        m_sync++;
        if (m_sync == 4) begin
          m_st = 3; m_ref = cyc; m_err = 0;
          win_q.delete();
        end
      end else if (cyc - m_ref >= 4095) begin
        model_enter_measure();
      end
    end else begin
      lo  = m_ui - m_ui / 4;
      bad = be && (len < lo || len > 4 * m_ui);
`ifdef SPDIF_LOCK_TRACK_EN
      if (be) begin
        win_q.push_back(len);
        if (win_q.size() == 64) begin
          mn = q_min();
          win_q.delete();
          if (mn - m_ui == 1 || m_ui - mn == 1) m_ui = mn;
        end
      end
`endif
      if (sy) begin
        m_ref = cyc; m_err = 0;
      end else begin
        if (bad) m_err++;
        if (cyc - m_ref >= 2047 || m_err >= 8) model_enter_measure();
      end
    end
    m_t1 = nt1; m_t2 = nt2; m_t3 = nt3;
  endtask

  // scoreboard helpers
  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [28:0] act_v, exp_v;
    act_v = {lock_state, audio_locked, dec_resetb, t1, t2, t3};
    exp_v = {m_st[1:0], (m_st == 3), (m_st >= 2), m_t1[7:0], m_t2[7:0], m_t3[7:0]};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL model: got {state,lock,rstb,t1,t2,t3}=%h expected %h (cycle %0d)", act_v, exp_v, cyc);
    end
  endtask

  // driver tasks (called at a falling edge, return at the next falling edge)
  task automatic tick(input logic en, input logic be, input logic [7:0] len, input logic sy);
    enable = en; bitedge_detected = be; bitlength = len; sync_found = sy;
    @(posedge clk_in);
    model_step(en, be, int'(len), sy);
    @(negedge clk_in);
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  task automatic go_verify(input logic [7:0] mn);
    do_reset();
    tick(1'b1, 1'b0, 8'd0, 1'b0);
    for (int k = 0; k < 64; k++)
      tick(1'b1, 1'b1, (k == 20) ? mn : mn + 8'd1 + 8'(k % 5), 1'b0);
  endtask

  task automatic go_locked(input logic [7:0] mn);
    go_verify(mn);
    idle(1);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 8'd0, 1'b1);
  endtask

  typedef struct {
    logic [7:0] min_len;
    logic [1:0] exp_state;
    logic [7:0] exp_t1;
    logic [7:0] exp_t2;
    logic [7:0] exp_t3;
  } row_t;

  row_t rows[6];

  initial begin
    int base;
    logic en_r, be_r, sy_r;
    logic [7:0] len_r;

    rows[0] = '{8'd14,  2'd2, 8'd21,  8'd35,  8'd39};
    rows[1] = '{8'd4,   2'd2, 8'd6,   8'd10,  8'd11};
    rows[2] = '{8'd80,  2'd2, 8'd120, 8'd200, 8'd220};
    rows[3] = '{8'd3,   2'd1, 8'd21,  8'd35,  8'd39};
    rows[4] = '{8'd81,  2'd1, 8'd21,  8'd35,  8'd39};
    rows[5] = '{8'd100, 2'd1, 8'd21,  8'd35,  8'd39};

    reset = 1'b1; enable = 1'b0; bitedge_detected = 1'b0; bitlength = 8'd0; sync_found = 1'b0;
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    check_val("rst_state", lock_state, 0);
    check_val("rst_locked", audio_locked, 0);
    check_val("rst_dec_resetb", dec_resetb, 0);
    check_val("rst_t1", t1, 21);
    check_val("rst_t2", t2, 35);
    check_val("rst_t3", t3, 39);
    reset = 1'b0;

    // measurement window outcomes and derived thresholds
    for (int r = 0; r < 6; r++) begin
      go_verify(rows[r].min_len);
      idle(1);
      check_val("row_state", lock_state, rows[r].exp_state);
      check_val("row_dec_resetb", dec_resetb, (rows[r].exp_state >= 2) ? 1 : 0);
      check_val("row_t1", t1, rows[r].exp_t1);
      check_val("row_t2", t2, rows[r].exp_t2);
      check_val("row_t3", t3, rows[r].exp_t3);
    end

    // four preambles 500 cycles apart lock the receiver
    go_verify(8'd14);
    for (int s = 0; s < 4; s++) begin
      tick(1'b1, 1'b0, 8'd0, 1'b1);
      if (s < 3) begin
        check_val("verify_not_locked", audio_locked, 0);
        idle(499);
      end
    end
    check_val("lock_audio", audio_locked, 1);
    check_val("lock_state", lock_state, 3);

    // watchdog expiry
    idle(2046);
    check_val("wd_hold", lock_state, 3);
    idle(1);
    check_val("wd_state", lock_state, 1);
    check_val("wd_audio", audio_locked, 0);
    check_val("wd_dec_resetb", dec_resetb, 0);

    // sync on the watchdog terminal cycle keeps lock
    go_locked(8'd14);
    idle(2046);
    tick(1'b1, 1'b0, 8'd0, 1'b1);
    check_val("wd_sync_prio", lock_state, 3);
    idle(2046);
    check_val("wd_sync_restart", lock_state, 3);

    // eight short edges without a sync drop lock
    go_locked(8'd14);
    for (int k = 0; k < 7; k++) tick(1'b1, 1'b1, 8'd3, 1'b0);
    check_val("err7_hold", lock_state, 3);
    tick(1'b1, 1'b1, 8'd3, 1'b0);
    check_val("err8_drop", lock_state, 1);

    // sync after seven errors clears the count
    go_locked(8'd14);
    for (int k = 0; k < 7; k++) tick(1'b1, 1'b1, 8'd3, 1'b0);
    tick(1'b1, 1'b0, 8'd0, 1'b1);
    for (int k = 0; k < 7; k++) tick(1'b1, 1'b1, 8'd3, 1'b0);
    check_val("err_cleared_by_sync", lock_state, 3);

    // sync coinciding with the eighth error edge, and over-long edges
    go_locked(8'd14);
    for (int k = 0; k < 7; k++) tick(1'b1, 1'b1, 8'd57, 1'b0);
    tick(1'b1, 1'b1, 8'd3, 1'b1);
    check_val("err8_sync_prio", lock_state, 3);
    for (int k = 0; k < 7; k++) tick(1'b1, 1'b1, 8'd10, 1'b0);
    check_val("err_after_prio", lock_state, 3);
    tick(1'b1, 1'b1, 8'd10, 1'b0);
    check_val("err_long_drop", lock_state, 1);

    // enable dropped mid-verify
    go_verify(8'd14);
    idle(5);
    tick(1'b0, 1'b0, 8'd0, 1'b0);
    check_val("disable_state", lock_state, 0);
    check_val("disable_dec_resetb", dec_resetb, 0);

    // verify timeout, and a sync on the terminal cycle postponing it
    go_verify(8'd14);
    idle(4094);
    check_val("vto_hold", lock_state, 2);
    idle(1);
    check_val("vto_state", lock_state, 1);
    go_verify(8'd14);
    idle(4094);
    tick(1'b1, 1'b0, 8'd0, 1'b1);
    check_val("vto_sync_prio", lock_state, 2);
    idle(1);
    check_val("vto_after_prio", lock_state, 1);

    // asynchronous reset between clock edges
    go_locked(8'd40);
    check_val("pre_rst_t1", t1, 60);
    reset = 1'b1;
    #1;
    check_val("async_rst_state", lock_state, 0);
    check_val("async_rst_audio", audio_locked, 0);
    check_val("async_rst_t1", t1, 21);
    model_reset();
    @(negedge clk_in);
    reset = 1'b0;
    idle(1);
    check_val("post_rst_measure", lock_state, 1);

    // ui behaviour while locked
    go_locked(8'd14);
    for (int k = 0; k < 64; k++) tick(1'b1, 1'b1, (k == 30) ? 8'd15 : 8'd20, 1'b0);
    idle(1);
`ifdef SPDIF_LOCK_TRACK_EN
    check_val("track_t1", t1, 22);
    check_val("track_t2", t2, 37);
    check_val("track_t3", t3, 42);
    for (int k = 0; k < 64; k++) tick(1'b1, 1'b1, (k == 30) ? 8'd18 : 8'd20, 1'b0);
    idle(1);
    check_val("track_ignore_t1", t1, 22);
    check_val("track_ignore_t3", t3, 42);
`else
    check_val("frozen_t1", t1, 21);
    check_val("frozen_t3", t3, 39);
`endif
    check_val("track_state", lock_state, 3);

    // randomized traffic against the model
    do_reset();
    for (int b = 0; b < 10; b++) begin
      base = $urandom_range(4, 60);
      for (int k = 0; k < 2000; k++) begin
        en_r  = ($urandom_range(0, 2999) != 0);
        be_r  = 1'($urandom_range(0, 1));
        len_r = ($urandom_range(0, 39) == 0) ? 8'($urandom_range(0, 255))
                                             : 8'(base + $urandom_range(0, 2 * base));
        sy_r  = ($urandom_range(0, 299) == 0);
        tick(en_r, be_r, len_r, sy_r);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
